// File: rtl/video_stream_packer_if.sv
// Pixel-in / AXI-Stream-out bundle for video_stream_packer.
// master: the packer itself (accepts pixels, drives the video stream).
// slave : the environment (pixel source and stream sink).
interface video_stream_packer_if;
    logic [23:0] in_pixel;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] out_stream_tdata;
    logic [3:0]  out_stream_tkeep;
    logic        out_stream_tlast;
    logic        out_stream_tuser;
    logic        out_stream_tvalid;
    logic        out_stream_tready;

    modport master (
        input  in_pixel, in_valid, out_stream_tready,
        output in_ready, out_stream_tdata, out_stream_tkeep,
               out_stream_tlast, out_stream_tuser, out_stream_tvalid
    );

    modport slave (
        output in_pixel, in_valid, out_stream_tready,
        input  in_ready, out_stream_tdata, out_stream_tkeep,
               out_stream_tlast, out_stream_tuser, out_stream_tvalid
    );
endinterface

// File: rtl/video_stream_packer.sv
// video_stream_packer: packs 24-bit RGB pixels, four at a time, into three
// 32-bit AXI-Stream words. tuser marks the first word of a frame, tlast the
// last word of each line, frame_done pulses after the final word of a frame.
// Optional macro PACKER_FRAME_SYNC_EN adds in_sof resynchronisation and a
// saturating sync_err_count.
module video_stream_packer #(
    parameter int X_PIXELS = 200,
    parameter int Y_SIZE   = 200
) (
    input  logic                  out_stream_aclk,
    input  logic                  periph_resetn,
    video_stream_packer_if.master strm,
    output logic                  frame_done
`ifdef PACKER_FRAME_SYNC_EN
    ,
    input  logic                  in_sof,
    output logic [7:0]            sync_err_count
`endif
);

    localparam int X_WORDS = X_PIXELS * 3 / 4;
    localparam int XW      = (X_WORDS > 1) ? $clog2(X_WORDS) : 1;
    localparam int YW      = (Y_SIZE > 1) ? $clog2(Y_SIZE) : 1;
    localparam logic [XW-1:0] X_LAST = XW'(X_WORDS - 1);
    localparam logic [YW-1:0] Y_LAST = YW'(Y_SIZE - 1);

    // Position of the next pixel inside its 4-pixel group.
    typedef enum logic [1:0] {
        PH_P0 = 2'd0,
        PH_P1 = 2'd1,
        PH_P2 = 2'd2,
        PH_P3 = 2'd3
    } phase_t;

    phase_t        phase_q, phase_d;
    logic [23:0]   hold_q, hold_d;
    logic [XW-1:0] x_word_q, x_word_d;
    logic [YW-1:0] y_line_q, y_line_d;
    logic [31:0]   tdata_q, tdata_d;
    logic          tlast_q, tlast_d;
    logic          tuser_q, tuser_d;
    logic          tvalid_q, tvalid_d;
    logic          frame_end_q, frame_end_d;
    logic          frame_done_q, frame_done_d;
    logic [7:0]    sync_err_q, sync_err_d;

    logic          accept;
    logic          out_fire;
    logic          load;
    logic          resync;
    logic [31:0]   load_word;

    // The output slot is either empty or draining this cycle; phase 0 never loads a word.
    assign strm.in_ready = (phase_q == PH_P0) || !tvalid_q || strm.out_stream_tready;

    assign accept   = strm.in_valid && strm.in_ready;
    assign out_fire = tvalid_q && strm.out_stream_tready;

    // Next-state: pixel packing, output slot management and line/frame counters.
    always_comb begin
        // NOTE: every comb output gets a default first so no path can infer a latch.
        phase_d      = phase_q;
        hold_d       = hold_q;
        x_word_d     = x_word_q;
        y_line_d     = y_line_q;
        tdata_d      = tdata_q;
        tlast_d      = tlast_q;
        tuser_d      = tuser_q;
        tvalid_d     = tvalid_q;
        frame_end_d  = frame_end_q;
        sync_err_d   = sync_err_q;
        load         = 1'b0;
        load_word    = 32'h0;
        resync       = 1'b0;

`ifdef PACKER_FRAME_SYNC_EN
        // SOF anywhere but the frame-start position restarts framing on this pixel.
        resync = accept && in_sof &&
                 !(phase_q == PH_P0 && x_word_q == '0 && y_line_q == '0);
`endif

        if (out_fire) begin
            tvalid_d = 1'b0;
        end

        if (resync) begin
            hold_d   = strm.in_pixel;
            phase_d  = PH_P1;
            x_word_d = '0;
            y_line_d = '0;
            if (sync_err_q != 8'hFF) begin
                sync_err_d = sync_err_q + 8'd1;
            end
        end else if (accept) begin
            case (phase_q)
                PH_P0: begin
                    hold_d  = strm.in_pixel;
                    phase_d = PH_P1;
                end
                PH_P1: begin
                    load_word = {strm.in_pixel[7:0], hold_q[23:0]};
                    hold_d    = {8'h00, strm.in_pixel[23:8]};
                    load      = 1'b1;
                    phase_d   = PH_P2;
                end
                PH_P2: begin
                    load_word = {strm.in_pixel[15:0], hold_q[15:0]};
                    hold_d    = {16'h0000, strm.in_pixel[23:16]};
                    load      = 1'b1;
                    phase_d   = PH_P3;
                end
                default: begin
                    load_word = {strm.in_pixel, hold_q[7:0]};
                    hold_d    = 24'h0;
                    load      = 1'b1;
                    phase_d   = PH_P0;
                end
            endcase
        end

        if (load) begin
            tdata_d     = load_word;
            tvalid_d    = 1'b1;
            tuser_d     = (x_word_q == '0) && (y_line_q == '0);
            tlast_d     = (x_word_q == X_LAST);
            frame_end_d = (x_word_q == X_LAST) && (y_line_q == Y_LAST);
            if (x_word_q == X_LAST) begin
                x_word_d = '0;
                y_line_d = (y_line_q == Y_LAST) ? '0 : y_line_q + YW'(1);
            end else begin
                x_word_d = x_word_q + XW'(1);
            end
        end

        frame_done_d = out_fire && tlast_q && frame_end_q;
    end

    // State register with synchronous active-low reset; reset drops any partial group or pending word.
    always_ff @(posedge out_stream_aclk) begin
        // NOTE: registers are updated with non-blocking assignments so every flop samples pre-edge values.
        if (!periph_resetn) begin
            phase_q      <= PH_P0;
            hold_q       <= 24'h0;
            x_word_q     <= '0;
            y_line_q     <= '0;
            tdata_q      <= 32'h0;
            tlast_q      <= 1'b0;
            tuser_q      <= 1'b0;
            tvalid_q     <= 1'b0;
            frame_end_q  <= 1'b0;
            frame_done_q <= 1'b0;
            sync_err_q   <= 8'h0;
        end else begin
            phase_q      <= phase_d;
            hold_q       <= hold_d;
            x_word_q     <= x_word_d;
            y_line_q     <= y_line_d;
            tdata_q      <= tdata_d;
            tlast_q      <= tlast_d;
            tuser_q      <= tuser_d;
            tvalid_q     <= tvalid_d;
            frame_end_q  <= frame_end_d;
            frame_done_q <= frame_done_d;
            sync_err_q   <= sync_err_d;
        end
    end

    assign strm.out_stream_tdata  = tdata_q;
    assign strm.out_stream_tkeep  = 4'hF;
    assign strm.out_stream_tlast  = tlast_q;
    assign strm.out_stream_tuser  = tuser_q;
    assign strm.out_stream_tvalid = tvalid_q;
    assign frame_done             = frame_done_q;

`ifdef PACKER_FRAME_SYNC_EN
    assign sync_err_count = sync_err_q;
`else
    logic unused_sync;
    assign unused_sync = ^sync_err_q;
`endif

endmodule
